// File: rtl/aes_pkg.sv
// Shared GF(2^8) helpers, column count and FSM encoding for the MixColumns engines.
// Inverse-coefficient multipliers exist only when MIX_COL_INV_EN is defined.
package aes_pkg;

  localparam int NB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

`ifdef MIX_COL_INV_EN
  // Higher coefficients are built from repeated doubling: x2, x4, x8.
  function automatic logic [7:0] gf_mul9(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ x;
  endfunction

  function automatic logic [7:0] gf_mulb(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
  endfunction

  function automatic logic [7:0] gf_muld(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
  endfunction

  function automatic logic [7:0] gf_mule(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
  endfunction
`endif

endpackage

// File: rtl/mix_col_word.sv
// Combinational single-column MixColumns; byte 0 sits in the most significant byte.
// With MIX_COL_INV_EN an inv input selects the inverse matrix.
module mix_col_word
  import aes_pkg::*;
(
`ifdef MIX_COL_INV_EN
  input  logic        inv,
`endif
  input  logic [31:0] col,
  output logic [31:0] mixed
);

  logic [7:0] a0, a1, a2, a3;
  logic [31:0] fwd;

  assign a0 = col[31:24];
  assign a1 = col[23:16];
  assign a2 = col[15:8];
  assign a3 = col[7:0];

  assign fwd = {xtime(a0) ^ gf_mul3(a1) ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ gf_mul3(a2) ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ gf_mul3(a3),
                gf_mul3(a0) ^ a1 ^ a2 ^ xtime(a3)};

`ifdef MIX_COL_INV_EN
  logic [31:0] rev;

  assign rev = {gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3),
                gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3),
                gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3),
                gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3)};

  assign mixed = inv ? rev : fwd;
`else
  assign mixed = fwd;
`endif

endmodule

// File: rtl/mix_col_iter.sv
// Iterative MixColumns: one column per clock through a single shared mixer.
// Optional MIX_COL_INV_EN adds an inv port that selects the inverse transform.
module mix_col_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
`ifdef MIX_COL_INV_EN
  input  logic         inv,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int CW = $clog2(NB);

  state_t            state;
  logic [CW-1:0]     col_cnt;
  logic [NB*32-1:0]  work_reg;
  logic [NB*32-1:0]  mixed_state;
  logic [31:0]       col_sel;
  logic [31:0]       col_mix;
  logic              accept;

  // A finished result may be replaced in the same cycle it is consumed.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign out_data  = work_reg;

  always_comb begin
    col_sel = '0;
    for (int c = 0; c < NB; c++) begin
      if (col_cnt == CW'(c)) col_sel = work_reg[NB*32-1-32*c -: 32];
    end
  end

`ifdef MIX_COL_INV_EN
  logic inv_reg;

  mix_col_word u_mix (
    .inv   (inv_reg),
    .col   (col_sel),
    .mixed (col_mix)
  );
`else
  mix_col_word u_mix (
    .col   (col_sel),
    .mixed (col_mix)
  );
`endif

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_col
      assign mixed_state[NB*32-1-32*gi -: 32] =
        (col_cnt == CW'(gi)) ? col_mix : work_reg[NB*32-1-32*gi -: 32];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      col_cnt  <= '0;
      work_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            work_reg <= in_data;
            col_cnt  <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          work_reg <= mixed_state;
          col_cnt  <= col_cnt + CW'(1);
          if (col_cnt == CW'(NB - 1)) state <= DONE;
        end
        DONE: begin
          if (accept) begin
            work_reg <= in_data;
            col_cnt  <= '0;
            state    <= BUSY;
          end else if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MIX_COL_INV_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    inv_reg <= 1'b0;
    else if (accept) inv_reg <= inv;
  end
`endif

endmodule

// File: tb/tb_mix_col_iter.sv
// Directed-vector bench for mix_col_iter: latency, backpressure, streaming, async reset.
module tb_mix_col_iter;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef MIX_COL_INV_EN
  logic         inv;
`endif

  int compared;
  int mismatched;

  localparam logic [127:0] V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] V2_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

  mix_col_iter dut (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef MIX_COL_INV_EN
    .inv       (inv),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called #1 after a rising edge with the DUT ready; returns edges from accept to out_valid.
  task automatic send_and_wait(input logic [127:0] d, output int lat);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    $display("xfer in=%h out=%h latency=%0d", d, out_data, lat);
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
`ifdef MIX_COL_INV_EN
    inv       = 1'b0;
`endif
    #12;
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    compared++;
    if (out_data !== 128'h0) begin mismatched++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_vector(input logic [127:0] vin, input logic [127:0] vout, input string nm);
    int lat;
    compared++;
    if (in_ready !== 1'b1) begin mismatched++; $display("FAIL %s_in_ready got=%b exp=1", nm, in_ready); end
    send_and_wait(vin, lat);
    compared++;
    if (lat !== 4) begin mismatched++; $display("FAIL %s_latency got=%0d exp=4", nm, lat); end
    compared++;
    if (out_data !== vout) begin mismatched++; $display("FAIL %s_data got=%h exp=%h", nm, out_data, vout); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL %s_drain got=%b exp=0", nm, out_valid); end
  endtask

  task automatic test_backpressure;
    int lat;
    send_and_wait(V1_IN, lat);
    compared++;
    if (lat !== 4) begin mismatched++; $display("FAIL bp_latency got=%0d exp=4", lat); end
    in_data = V2_IN;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      compared++;
      if (out_valid !== 1'b1 || out_data !== V1_OUT || in_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL bp_hold cyc=%0d valid=%b ready=%b data=%h exp valid=1 ready=0 data=%h",
                 i, out_valid, in_ready, out_data, V1_OUT);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_release got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back;
    int lat;
    int hits;
    int last;
    send_and_wait(V1_IN, lat);
    compared++;
    if (out_data !== V1_OUT) begin mismatched++; $display("FAIL b2b_first got=%h exp=%h", out_data, V1_OUT); end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = V2_IN;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_handoff got=%b exp=0", out_valid); end
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
    $display("xfer in=%h out=%h latency=%0d", V2_IN, out_data, lat);
    compared++;
    if (lat !== 4) begin mismatched++; $display("FAIL b2b_latency got=%0d exp=4", lat); end
    compared++;
    if (out_data !== V2_OUT) begin mismatched++; $display("FAIL b2b_second got=%h exp=%h", out_data, V2_OUT); end

    // Sustained streaming: out_ready and in_valid held high from DONE.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = V1_IN;
    hits = 0;
    last = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        $display("xfer stream in=%h out=%h cycle=%0d", V1_IN, out_data, i);
        compared++;
        if (out_data !== V1_OUT) begin mismatched++; $display("FAIL stream_data got=%h exp=%h", out_data, V1_OUT); end
        if (hits > 0) begin
          compared++;
          if (i - last !== 5) begin mismatched++; $display("FAIL stream_period got=%0d exp=5", i - last); end
        end
        hits++;
        last = i;
      end
    end
    compared++;
    if (hits !== 4) begin mismatched++; $display("FAIL stream_count got=%0d exp=4", hits); end
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (in_ready) break;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    in_data  = V2_IN;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL mid_reset_valid got=%b exp=0", out_valid); end
    compared++;
    if (out_data !== 128'h0) begin mismatched++; $display("FAIL mid_reset_data got=%h exp=0", out_data); end
    #5;
    reset_n = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (in_ready !== 1'b1) begin mismatched++; $display("FAIL mid_reset_ready got=%b exp=1", in_ready); end
    test_vector(V2_IN, V2_OUT, "post_reset");
  endtask

`ifdef MIX_COL_INV_EN
  task automatic test_inverse;
    inv = 1'b1;
    test_vector(V1_OUT, V1_IN, "inverse");
    inv = 1'b0;
  endtask
`endif

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset;
    test_vector(V1_IN, V1_OUT, "fips");
    test_vector(V2_IN, V2_OUT, "second");
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
`ifdef MIX_COL_INV_EN
    test_inverse;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
